// File: rtl/mcs_fpro_bridge_mr.sv
// MCS IO bus to FPro multi-region bridge with registered FPro strobes.
// Define BRG_TIMEOUT_EN to abort slave waits after TIMEOUT cycles.
module mcs_fpro_bridge_mr #(
  parameter logic [31:0] BRG_BASE = 32'hc000_0000,
  parameter int N_REGION = 4,
  parameter int ADDR_W = 21,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  io_addr_strobe,
  input  logic                  io_read_strobe,
  input  logic                  io_write_strobe,
  input  logic [3:0]            io_byte_enable,
  input  logic [31:0]           io_address,
  input  logic [31:0]           io_write_data,
  output logic [31:0]           io_read_data,
  output logic                  io_ready,
  output logic [N_REGION-1:0]   fp_cs,
  output logic                  fp_wr,
  output logic                  fp_rd,
  output logic [ADDR_W-1:0]     fp_addr,
  output logic [31:0]           fp_wr_data,
  output logic [3:0]            fp_be,
  input  logic [32*N_REGION-1:0] fp_rd_data,
  input  logic [N_REGION-1:0]   fp_ack,
  input  logic                  err_clr,
  output logic                  err_flag,
  output logic [31:0]           err_addr
);

  localparam int RSEL_W = $clog2(N_REGION);

  if (ADDR_W + RSEL_W > 22) begin : g_bad_map
    $error("region select field does not fit in io_address[23:2]");
  end
  if (N_REGION < 2 || N_REGION > 8) begin : g_bad_nreg
    $error("N_REGION must be 2..8");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_tmo
    $error("TIMEOUT must be 1..65535");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t                state_q, state_d;
  logic [RSEL_W-1:0]     idx_q, idx_d;
  logic [31:0]           addr_q, addr_d;
  logic [N_REGION-1:0]   fp_cs_q, fp_cs_d;
  logic                  fp_wr_q, fp_wr_d;
  logic                  fp_rd_q, fp_rd_d;
  logic [ADDR_W-1:0]     fp_addr_q, fp_addr_d;
  logic [31:0]           fp_wr_data_q, fp_wr_data_d;
  logic [3:0]            fp_be_q, fp_be_d;
  logic                  io_ready_q, io_ready_d;
  logic [31:0]           io_read_data_q, io_read_data_d;
  logic                  err_flag_q, err_flag_d;
  logic [31:0]           err_addr_q, err_addr_d;
`ifdef BRG_TIMEOUT_EN
  logic [15:0]           cnt_q, cnt_d;
`endif

  logic [21:0]       req_wa;
  logic [RSEL_W-1:0] req_idx;
  logic              req_hit;
  logic              req_ok;
  logic              ack_hit;
  logic [31:0]       rd_word;
  logic              err_set;
  logic [31:0]       err_src;
  logic              unused_bits;

  assign req_wa  = io_address[23:2];
  assign req_idx = req_wa[ADDR_W +: RSEL_W];
  assign req_hit = io_addr_strobe
                 && (io_read_strobe || io_write_strobe)
                 && (io_address[31:24] == BRG_BASE[31:24]);
  assign req_ok  = int'(req_idx) < N_REGION;
  assign ack_hit = fp_ack[idx_q];
  assign rd_word = fp_rd_data[{idx_q, 5'd0} +: 32];
  assign unused_bits = ^{io_address[1:0], req_wa};

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    addr_d         = addr_q;
    fp_cs_d        = fp_cs_q;
    fp_wr_d        = 1'b0;
    fp_rd_d        = 1'b0;
    fp_addr_d      = fp_addr_q;
    fp_wr_data_d   = fp_wr_data_q;
    fp_be_d        = fp_be_q;
    io_ready_d     = 1'b0;
    io_read_data_d = io_read_data_q;
    err_set        = 1'b0;
    err_src        = addr_q;
`ifdef BRG_TIMEOUT_EN
    cnt_d          = '0;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_hit) begin
          idx_d        = req_idx;
          addr_d       = io_address;
          fp_addr_d    = req_wa[ADDR_W-1:0];
          fp_wr_data_d = io_write_data;
          fp_be_d      = io_byte_enable;
          if (req_ok) begin
            state_d          = ACCESS;
            fp_cs_d          = '0;
            fp_cs_d[req_idx] = 1'b1;
            fp_wr_d          = io_write_strobe;
            fp_rd_d          = !io_write_strobe;
          end else begin
            state_d        = DONE;
            io_ready_d     = 1'b1;
            io_read_data_d = '0;
            err_set        = 1'b1;
            err_src        = io_address;
          end
        end
      end
      ACCESS: begin
        if (ack_hit) begin
          state_d        = DONE;
          io_ready_d     = 1'b1;
          io_read_data_d = rd_word;
          fp_cs_d        = '0;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (ack_hit) begin
          state_d        = DONE;
          io_ready_d     = 1'b1;
          io_read_data_d = rd_word;
          fp_cs_d        = '0;
        end
`ifdef BRG_TIMEOUT_EN
        else if (cnt_q + 16'd1 == 16'(TIMEOUT)) begin
          state_d        = DONE;
          io_ready_d     = 1'b1;
          io_read_data_d = '0;
          fp_cs_d        = '0;
          err_set        = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // a new error beats a clear in the same cycle
    err_flag_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_flag_q);
    err_addr_d = (err_set && !err_flag_q) ? err_src : err_addr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      addr_q         <= '0;
      fp_cs_q        <= '0;
      fp_wr_q        <= 1'b0;
      fp_rd_q        <= 1'b0;
      fp_addr_q      <= '0;
      fp_wr_data_q   <= '0;
      fp_be_q        <= '0;
      io_ready_q     <= 1'b0;
      io_read_data_q <= '0;
      err_flag_q     <= 1'b0;
      err_addr_q     <= '0;
`ifdef BRG_TIMEOUT_EN
      cnt_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      addr_q         <= addr_d;
      fp_cs_q        <= fp_cs_d;
      fp_wr_q        <= fp_wr_d;
      fp_rd_q        <= fp_rd_d;
      fp_addr_q      <= fp_addr_d;
      fp_wr_data_q   <= fp_wr_data_d;
      fp_be_q        <= fp_be_d;
      io_ready_q     <= io_ready_d;
      io_read_data_q <= io_read_data_d;
      err_flag_q     <= err_flag_d;
      err_addr_q     <= err_addr_d;
`ifdef BRG_TIMEOUT_EN
      cnt_q          <= cnt_d;
`endif
    end
  end

  assign io_read_data = io_read_data_q;
  assign io_ready     = io_ready_q;
  assign fp_cs        = fp_cs_q;
  assign fp_wr        = fp_wr_q;
  assign fp_rd        = fp_rd_q;
  assign fp_addr      = fp_addr_q;
  assign fp_wr_data   = fp_wr_data_q;
  assign fp_be        = fp_be_q;
  assign err_flag     = err_flag_q;
  assign err_addr     = err_addr_q;

endmodule
